// File: rtl/seg_scan_pkg.sv
// Shared constants and the brightness helper for the multiplexed seven-segment scanner.
package seg_scan_pkg;

    localparam int unsigned SEG_OFF   = 0;
    localparam int unsigned GHOST_CYC = 2;

    // Number of prescaler counts per slot during which a digit may be lit.
    function automatic int unsigned on_cycles(input logic [3:0] bright, input int unsigned div);
        return ((32'(bright) + 32'd1) * div) >> 4;
    endfunction

endpackage

// File: rtl/seg_scan_presc.sv
// Slot prescaler and digit-slot counter; wrap pulses on the cycle idx returns to 0.
module seg_scan_presc #(
    parameter  int DIGITS = 4,
    parameter  int DIV    = 1000,
    localparam int PW     = $clog2(DIV),
    localparam int IW     = $clog2(DIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [PW-1:0] presc,
    output logic [IW-1:0] idx,
    output logic          wrap
);

    logic slot_end;
    logic last_slot;

    assign slot_end  = (presc == PW'(DIV - 1));
    assign last_slot = (idx == IW'(DIGITS - 1));
    assign wrap      = en && slot_end && last_slot;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (!en) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= last_slot ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner with frame-coherent shadows, blanking and brightness PWM.
// Optional SEG_GHOST_BLANK_EN forces the first GHOST_CYC clocks of each slot dark.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter  int DIGITS = 4,
    parameter  int SEG_W  = 8,
    parameter  int DIV    = 1000,
    localparam int PW     = $clog2(DIV),
    localparam int IW     = $clog2(DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [DIGITS*SEG_W-1:0] seg_in,
    input  logic [DIGITS-1:0]       blank,
    input  logic [3:0]              bright,
    output logic [SEG_W-1:0]        seg_d,
    output logic [DIGITS-1:0]       seg_w,
    output logic                    frame_start
);

    logic [PW-1:0] presc;
    logic [IW-1:0] idx;
    logic          wrap;

    seg_scan_presc #(
        .DIGITS(DIGITS),
        .DIV   (DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .presc(presc),
        .idx  (idx),
        .wrap (wrap)
    );

    logic [DIGITS*SEG_W-1:0] sh_seg;
    logic [DIGITS-1:0]       sh_blank;
    logic [3:0]              sh_bright;

    // Shadows only change at a frame boundary (or freely while idle) so a frame never mixes data.
    // NOTE: shadows are reset so the first frame after reset shows a known all-off code.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_seg    <= '0;
            sh_blank  <= '0;
            sh_bright <= '0;
        end else if (!en || wrap) begin
            sh_seg    <= seg_in;
            sh_blank  <= blank;
            sh_bright <= bright;
        end
    end

    logic [IW-1:0]     f;
    logic [SEG_W-1:0]  field;
    logic [DIGITS-1:0] sel;
    int unsigned       on_cyc;
    logic              win;
    logic              lit;

    // NOTE: every always_comb output is assigned on every path; a missed one would infer a latch.
    always_comb begin
        f      = IW'(DIGITS - 1) - idx;
        field  = SEG_W'(sh_seg >> (32'(f) * 32'(SEG_W)));
        sel    = DIGITS'(1) << f;
        on_cyc = on_cycles(sh_bright, DIV);
`ifdef SEG_GHOST_BLANK_EN
        win    = (32'(presc) >= GHOST_CYC) && (32'(presc) < on_cyc);
`else
        win    = 32'(presc) < on_cyc;
`endif
        lit    = en && !sh_blank[f] && win;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_d       <= '0;
            seg_w       <= '0;
            frame_start <= 1'b0;
        end else begin
            seg_d       <= lit ? field : SEG_W'(SEG_OFF);
            seg_w       <= lit ? sel : '0;
            frame_start <= en && (presc == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues per-cycle expectations, a negedge monitor compares.
module tb_seg_scan_mux;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 8;
    localparam int DIV    = 16;
`ifdef SEG_GHOST_BLANK_EN
    localparam bit GHOST = 1'b1;
`else
    localparam bit GHOST = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    en  = 1'b0;
    logic [DIGITS*SEG_W-1:0] seg_in = '0;
    logic [DIGITS-1:0]       blank  = '0;
    logic [3:0]              bright = '0;
    logic [SEG_W-1:0]        seg_d;
    logic [DIGITS-1:0]       seg_w;
    logic                    frame_start;

    seg_scan_mux #(
        .DIGITS(DIGITS),
        .SEG_W (SEG_W),
        .DIV   (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .seg_in     (seg_in),
        .blank      (blank),
        .bright     (bright),
        .seg_d      (seg_d),
        .seg_w      (seg_w),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] w;
        logic [7:0] d;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   mon_n  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("scan cycle %0d {seg_w,seg_d,fs}", mon_n),
                  32'({seg_w, seg_d, frame_start}), 32'(e));
            mon_n++;
        end
    end

    // Expected 64-cycle frame: DIV = 16 gives on_cycles = bright + 1.
    task automatic push_frame(input logic [31:0] codes, input int br, input logic [3:0] blk);
        exp_t e;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 16; c++) begin
                int  f;
                bit  lit;
                f    = 3 - s;
                lit  = !blk[f] && (c < br + 1) && (!GHOST || c >= 2);
                e.w  = lit ? 4'(1 << f) : 4'h0;
                e.d  = lit ? codes[f*8 +: 8] : 8'h00;
                e.fs = (s == 0 && c == 0);
                q.push_back(e);
            end
        end
    endtask

    // Called #1 after the edge that shows cycle 0; returns #1 after cycle 0 of the next frame.
    task automatic run_frame(input logic [31:0] codes, input int br, input logic [3:0] blk,
                             input int apply_at, input logic [31:0] n_seg,
                             input logic [3:0] n_blank, input logic [3:0] n_bright);
        push_frame(codes, br, blk);
        repeat (apply_at) @(posedge clk);
        #1;
        seg_in = n_seg;
        blank  = n_blank;
        bright = n_bright;
        repeat (64 - apply_at) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] CODES = 32'h3F06_5B4F;
    localparam logic [31:0] ALLFF = 32'hFFFF_FFFF;

    initial begin
        exp_t e;
        seg_in = CODES;
        bright = 4'd15;
        blank  = 4'b0000;
        en     = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("reset seg_w", 32'(seg_w), 32'h0);
        check("reset seg_d", 32'(seg_d), 32'h0);
        check("reset frame_start", 32'(frame_start), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Cleared shadows first, then full brightness, dimmed, blanked, mid-frame change.
        run_frame(32'h0, 0,  4'b0000, 62, CODES, 4'b0000, 4'd15);
        run_frame(CODES, 15, 4'b0000, 62, CODES, 4'b0000, 4'd3);
        run_frame(CODES, 3,  4'b0000, 62, CODES, 4'b0100, 4'd15);
        run_frame(CODES, 15, 4'b0100, 62, CODES, 4'b0000, 4'd15);
        run_frame(CODES, 15, 4'b0000, 40, ALLFF, 4'b0000, 4'd15);
        run_frame(ALLFF, 15, 4'b0000, 62, ALLFF, 4'b0000, 4'd15);

        // Asynchronous reset in the middle of a lit slot.
        repeat (5) @(posedge clk);
        #2;
        check("lit before reset seg_w", 32'(seg_w), 32'h8);
        check("lit before reset seg_d", 32'(seg_d), 32'hFF);
        rst = 1'b0;
        #1;
        check("async reset seg_w", 32'(seg_w), 32'h0);
        check("async reset seg_d", 32'(seg_d), 32'h0);
        check("async reset frame_start", 32'(frame_start), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        run_frame(32'h0, 0,  4'b0000, 62, ALLFF, 4'b0000, 4'd15);
        run_frame(ALLFF, 15, 4'b0000, 62, ALLFF, 4'b0000, 4'd15);

        // en falls after cycle 3 of slot 0: dark from cycle 4 on.
        for (int c = 0; c < 6; c++) begin
            bit lit;
            lit  = (c < 4) && (!GHOST || c >= 2);
            e.w  = lit ? 4'b1000 : 4'h0;
            e.d  = lit ? 8'hFF : 8'h00;
            e.fs = (c == 0);
            q.push_back(e);
        end
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 seg_in = CODES;
        repeat (4) @(posedge clk);
        #1 en = 1'b1;
        @(posedge clk);
        #1;
        // Shadows followed the inputs while idle, so the new codes show at once.
        run_frame(CODES, 15, 4'b0000, 62, CODES, 4'b0000, 4'd15);

        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        check("scoreboard drained", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule
